// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the pipelined adder/subtractor.
package addsub_pkg;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
endpackage

// File: rtl/addsub_slice.sv
// One slice of the carry chain: plain W-bit ripple add, purely combinational.
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);
  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int k = 0; k < W; k++) begin
      sum[k]   = a[k] ^ b[k] ^ c[k];
      c[k+1]   = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
  end

  assign cout    = c[W];
  assign msb_cin = c[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Carry-chain pipelined add/sub: rank 0 captures operands, rank i+1 holds the
// result after slice i; every rank shifts together under a single advance.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = (STAGES < 1) ? WIDTH : WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic                          advance;
  logic [STAGES:0]               vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [STAGES:0]               c_q, c_d;
  logic [STAGES:1][WIDTH-1:0]    s_q, s_d;
  logic                          ovf_q, ovf_d;

  logic [STAGES-1:0][SLICE-1:0]  sl_sum;
  logic [STAGES-1:0]             sl_cout, sl_msbc;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    addsub_slice #(.W(SLICE)) u_slice (
      .a       (a_q[g][g*SLICE +: SLICE]),
      .b       (b_q[g][g*SLICE +: SLICE]),
      .cin     (c_q[g]),
      .sum     (sl_sum[g]),
      .cout    (sl_cout[g]),
      .msb_cin (sl_msbc[g])
    );
  end

  // Operand bits below the active slice of the last rank are dead; synthesis prunes them.
  logic unused_consumed;
  assign unused_consumed = ^{a_q[STAGES-1], b_q[STAGES-1]};

  always_comb begin
    a_d        = '0;
    b_d        = '0;
    c_d        = '0;
    s_d        = '0;
    advance    = !vld_pipe_q[STAGES] || out_ready;
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};

    a_d[0] = a;
    b_d[0] = (op == SUB) ? ~b : b;
    c_d[0] = (op == SUB) ? 1'b1 : cin;
    for (int i = 1; i < STAGES; i++) begin
      a_d[i] = a_q[i-1];
      b_d[i] = b_q[i-1];
    end

    for (int i = 0; i < STAGES; i++) c_d[i+1] = sl_cout[i];

    s_d[1][SLICE-1:0] = sl_sum[0];
    for (int i = 1; i < STAGES; i++) begin
      s_d[i+1]                   = s_q[i];
      s_d[i+1][i*SLICE +: SLICE] = sl_sum[i];
    end

    ovf_d = sl_cout[STAGES-1] ^ sl_msbc[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      s_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (advance) begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      s_q        <= s_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: table vectors, streaming, stall and mid-flight reset.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         cin = 1'b0, cout, ovf;
  op_e          op = ADD;
  logic         out_valid, out_ready = 1'b1;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    op_e          op;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, passes = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endfunction

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic xc, input op_e xo);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         v;
    bb = (xo == SUB) ? ~xb : xb;
    r  = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, (xo == SUB) ? 1'b1 : xc};
    v  = (xa[W-1] == bb[W-1]) && (r[W-1] != xa[W-1]);
    return {v, r[W], r[W-1:0]};
  endfunction

  // Transfers happen at the next rising edge; inputs and outputs are stable here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", 32'({ovf, cout, sum}), 32'({mon_e.ov, mon_e.co, mon_e.s}));
        if (mon_e.lat) chk("latency", cyc - mon_e.acc, S);
      end
    end
  end

  // Called aligned to posedge+#1; returns aligned the same way.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input op_e to, input logic [W+1:0] ex, input bit lat);
    bit done;
    done     = 1'b0;
    a        = ta;
    b        = tb_;
    cin      = tc;
    op       = to;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{s: ex[W-1:0], co: ex[W], ov: ex[W+1], acc: cyc + 1, lat: lat});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t         tbl[10];
  logic [W-1:0] ra, rb;
  logic         rc;
  op_e          ro;
  int           seen;

  initial begin
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, ADD, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, SUB, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h0003, 16'h0005, 1'b0, SUB, 16'hFFFE, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, ADD, 16'h5556, 1'b0, 1'b0};
    tbl[6] = '{16'h0005, 16'h0005, 1'b1, SUB, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, ADD, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, ADD, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, SUB, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_outputs", 32'({ovf, cout, sum}), 0);
    rst_n = 1'b1;

    // Isolated table vectors, each with a latency check.
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op, {tbl[i].ov, tbl[i].co, tbl[i].s}, 1'b1);
      repeat (S + 1) @(posedge clk);
      #1;
    end

    // Back-to-back stream: fixed latency on every item implies consecutive output cycles.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ro = op_e'($urandom_range(0, 1));
      send(ra, rb, rc, ro, model(ra, rb, rc, ro), 1'b1);
    end
    repeat (S + 2) @(posedge clk);
    #1;
    chk("stream_drained", sbq.size(), 0);

    // Fill the pipe with the consumer stalled, then hold for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < S + 1; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send(ra, rb, 1'b0, ADD, model(ra, rb, 1'b0, ADD), 1'b0);
    end
    ra = 16'hABCD;
    rb = 16'h1111;
    a = ra; b = rb; cin = 1'b0; op = SUB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_hold", 32'({ovf, cout, sum}), 32'({sbq[0].ov, sbq[0].co, sbq[0].s}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(ra, rb, 1'b0, SUB, model(ra, rb, 1'b0, SUB), 1'b0);
    repeat (S + 8) @(posedge clk);
    #1;
    chk("stall_drained", sbq.size(), 0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send(ra, rb, 1'b1, ADD, model(ra, rb, 1'b1, ADD), 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_outputs", 32'({ovf, cout, sum}), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    sbq.delete();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_reset_quiet", seen, 0);
    @(posedge clk); #1;

    send(16'h0F0F, 16'h00F1, 1'b0, ADD, {1'b0, 1'b0, 16'h1000}, 1'b1);
    repeat (S + 3) @(posedge clk);
    #1;
    chk("final_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
